// File: rtl/psd_pkg.sv
// psd_pkg: shared state encoding and sizing helpers for the PSD averaging controller
package psd_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} psd_state_t;
   function automatic int psd_nbins(input int nbins_log2);
      return 1 << nbins_log2;
   endfunction
   function automatic int psd_nsegs(input int nseg_log2);
      return 1 << nseg_log2;
   endfunction
   function automatic bit psd_acc_w_ok(input int mag_w, input int acc_w, input int nseg_log2);
      return acc_w >= mag_w + nseg_log2;
   endfunction
endpackage

// File: rtl/psd_bin_ram.sv
// psd_bin_ram: L x DW register array, combinational read, synchronous write
module psd_bin_ram #(
   parameter int AW = 6,
   parameter int DW = 40
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [1<<AW];
   assign rdata = mem[addr];
   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;
endmodule

// File: rtl/psd_avg_controller.sv
// psd_avg_controller: accumulates |X|^2 per bin over K segments, then drains sum >> NSEG_LOG2
module psd_avg_controller
   import psd_pkg::*;
#(
   parameter int MAG_W      = 32,
   parameter int ACC_W      = 40,
   parameter int NBINS_LOG2 = 6,
   parameter int NSEG_LOG2  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [MAG_W-1:0]      in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      out_data,
   output logic [NBINS_LOG2-1:0] out_bin,
   output logic                  out_last,
   output logic                  err_len
);
   localparam int K  = psd_nsegs(NSEG_LOG2);
   localparam int SW = NSEG_LOG2 > 0 ? NSEG_LOG2 : 1;

   if (!psd_acc_w_ok(MAG_W, ACC_W, NSEG_LOG2)) begin : g_bad_acc_w
      $error("ACC_W must be >= MAG_W + NSEG_LOG2");
   end
   if (NBINS_LOG2 < 1) begin : g_bad_nbins
      $error("NBINS_LOG2 must be >= 1");
   end

   psd_state_t state, next;
   logic [NBINS_LOG2-1:0] bin_cnt;
   logic [SW-1:0]         seg_cnt;
   logic [ACC_W-1:0]      rd_data, wr_data;
   logic bin_last, seg_last, in_hs, out_hs, go;

   assign bin_last = &bin_cnt;
   assign seg_last = seg_cnt == SW'(K - 1);
   assign go       = state == IDLE && start && !abort;
   assign in_hs    = state == ACCUM && in_valid && !abort;
   assign out_hs   = state == DRAIN && out_ready && !abort;
   assign wr_data  = seg_cnt == '0 ? ACC_W'(in_data) : rd_data + ACC_W'(in_data);

   assign busy      = state != IDLE;
   assign done      = state == DONE;
   assign in_ready  = state == ACCUM;
   assign out_valid = state == DRAIN;
   assign out_last  = out_valid && bin_last;
   assign out_data  = out_valid ? rd_data >> NSEG_LOG2 : '0;
   assign out_bin   = out_valid ? bin_cnt : '0;

   // bin_cnt doubles as the drain index; it has wrapped to 0 when DRAIN begins
   psd_bin_ram #(.AW(NBINS_LOG2), .DW(ACC_W)) u_ram (
      .clk   (clk),
      .we    (in_hs),
      .addr  (bin_cnt),
      .wdata (wr_data),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= next;

   always_comb begin
      next = state;
      unique case (state)
         IDLE:    next = go ? ACCUM : IDLE;
         ACCUM:   next = abort ? IDLE : (in_hs && bin_last && seg_last) ? DRAIN : ACCUM;
         DRAIN:   next = abort ? IDLE : (out_hs && bin_last) ? DONE : DRAIN;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bin_cnt <= '0;
         seg_cnt <= '0;
         err_len <= 1'b0;
      end else if (go) begin
         bin_cnt <= '0;
         seg_cnt <= '0;
         err_len <= 1'b0;
      end else if (in_hs) begin
         bin_cnt <= bin_cnt + 1'b1;
         if (bin_last) seg_cnt <= seg_cnt + 1'b1;
         if (in_last != bin_last) err_len <= 1'b1;
      end else if (out_hs) begin
         bin_cnt <= bin_cnt + 1'b1;
      end
endmodule

// File: tb/tb_psd_avg_controller.sv
// tb_psd_avg_controller: scoreboard bench, L=4, K=4, MAG_W=8, ACC_W=10
module tb_psd_avg_controller;
   typedef struct packed {
      logic [1:0] bin;
      logic [9:0] data;
      logic       last;
   } exp_t;

   logic       clk = 0, rst = 1, start = 0, abort = 0;
   logic       in_valid = 0, in_last = 0, out_ready = 1;
   logic [7:0] in_data = 0;
   logic       busy, done, in_ready, out_valid, out_last, err_len;
   logic [9:0] out_data;
   logic [1:0] out_bin;

   int   n_chk = 0, n_fail = 0, done_cnt = 0;
   bit   bp = 0;
   exp_t q[$];
   int   exp_tab[3][4] = '{'{8, 8, 8, 8}, '{1, 5, 9, 13}, '{255, 255, 255, 255}};
   bit   bp_pat[4] = '{1, 0, 0, 1};

   psd_avg_controller #(.MAG_W(8), .ACC_W(10), .NBINS_LOG2(2), .NSEG_LOG2(2)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_bin(out_bin), .out_last(out_last), .err_len(err_len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin : bp_drv
      int k = 0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp ? bp_pat[k % 4] : 1'b1;
         k++;
      end
   end

   initial begin : monitor
      bit         stall = 0, exp_done = 0;
      logic [9:0] p_data;
      logic [1:0] p_bin;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall    = 0;
            exp_done = 0;
         end else begin
            if (exp_done || done) chk("done_timing", done, exp_done);
            if (done) done_cnt++;
            exp_done = 0;
            if (out_valid && stall) chk("stall_stable", {out_bin, out_data}, {p_bin, p_data});
            if (out_valid && out_ready) begin
               if (q.size() == 0) chk("unexpected_output", 1, 0);
               else begin
                  e = q.pop_front();
                  chk("out_bin", out_bin, e.bin);
                  chk("out_data", out_data, e.data);
                  chk("out_last", out_last, e.last);
                  exp_done = e.last;
               end
            end
            stall  = out_valid && !out_ready;
            p_data = out_data;
            p_bin  = out_bin;
         end
      end
   end

   task automatic run(input int mode, input bit bad, input int abort_at, input bit rst_drain,
                      input bit stray);
      int d0, v;
      exp_t e;
      d0 = done_cnt;
      for (int b = 0; b < 4; b++) begin
         e.bin  = 2'(b);
         e.data = 10'(exp_tab[mode][b]);
         e.last = b == 3;
         q.push_back(e);
      end
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      chk("accum_entry", {busy, in_ready, out_valid, err_len}, 4'b1100);
      for (int n = 0; n < 16; n++) begin
         v        = mode == 0 ? 8 : mode == 1 ? 4 * (n % 4) + n / 4 : 255;
         in_valid = 1;
         in_data  = 8'(v);
         in_last  = (n % 4) == 3;
         if (bad && n == 1) in_last = 1;
         if (bad && n == 11) in_last = 0;
         abort = n == abort_at;
         @(posedge clk); #1;
         if (n == abort_at) begin
            abort    = 0;
            in_valid = 0;
            q.delete();
            chk("abort_idle", {busy, in_ready, out_valid}, 3'b000);
            repeat (5) @(posedge clk);
            #1 chk("abort_no_done", done_cnt, d0);
            return;
         end
         chk("err_len", err_len, bad && n >= 1);
      end
      in_valid = 0;
      in_last  = 0;
      chk("drain_latency", out_valid, 1);
      if (stray) begin
         start = 1;
         @(posedge clk); #1 start = 0;
      end
      if (rst_drain) begin
         @(posedge clk); #1 rst = 1;
         #1 chk("rst_outputs", {busy, done, in_ready, out_valid, out_last, err_len, out_data, out_bin}, 0);
         q.delete();
         @(posedge clk); #1 rst = 0;
         return;
      end
      for (int t = 0; t < 60 && done_cnt == d0; t++) @(posedge clk);
      if (done_cnt == d0) chk("done_timeout", 0, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("done_count", done_cnt - d0, 1);
      chk("queue_empty", q.size(), 0);
      chk("idle_after", {busy, err_len}, {1'b0, bad});
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 chk("reset_state", {busy, done, in_ready, out_valid, out_last, err_len, out_data, out_bin}, 0);
      rst = 0;
      run(0, 0, -1, 0, 0);
      run(1, 0, -1, 0, 0);
      bp = 1;
      run(0, 0, -1, 0, 0);
      run(1, 0, -1, 0, 0);
      bp = 0;
      run(1, 1, -1, 0, 0);
      run(0, 0, -1, 0, 0);
      run(2, 0, -1, 0, 0);
      run(0, 0, 5, 0, 0);
      run(0, 0, -1, 1, 0);
      run(0, 0, -1, 0, 0);
      run(1, 0, -1, 0, 1);
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
